// File: rtl/key_defs.sv
// Shared key-handling definitions: event FSM state codes and the 50 MHz timing
// defaults, so the debouncer and the event classifier agree on the same clock.
package key_defs;

   typedef enum logic [2:0] {
      ST_ARM       = 3'd0,
      ST_IDLE      = 3'd1,
      ST_PRESS1    = 3'd2,
      ST_WAIT2     = 3'd3,
      ST_PRESS2    = 3'd4,
      ST_LONG_HOLD = 3'd5
   } state_t;

   localparam int LONG_CYC_DEF   = 50_000_000;  // 1 s
   localparam int DBL_CYC_DEF    = 12_500_000;  // 250 ms
   localparam int REPEAT_CYC_DEF = 10_000_000;  // 200 ms
   localparam int CNT_W_DEF      = 26;

endpackage

// File: rtl/key_event.sv
// Classifies debounced key presses into short press, double click and long press,
// with auto-repeat ticks while a long press is held. All event outputs are one-cycle pulses.
module key_event
   import key_defs::*;
#(
   parameter logic PRESS_LEVEL = 1'b0,
   parameter int   LONG_CYC    = LONG_CYC_DEF,
   parameter int   DBL_CYC     = DBL_CYC_DEF,
   parameter int   REPEAT_CYC  = REPEAT_CYC_DEF,
   parameter int   CNT_W       = CNT_W_DEF
) (
   input  logic sys_clk,
   input  logic sys_rst,
   input  logic key_status,
   output logic short_press,
   output logic double_click,
   output logic long_press,
   output logic repeat_tick,
   output logic key_busy
);

   // The sample that enters a press/gap state is already sample 1, and cnt reads 0
   // on sample 2, so the N-th sample is seen at cnt == N-2. LONG_HOLD starts fresh.
   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 2);
   localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_CYC - 2);
   localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYC - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             pressed;

   assign pressed  = (key_status == PRESS_LEVEL);
   assign key_busy = (state != ST_ARM) && (state != ST_IDLE);

   // NOTE: all state lives in one clocked block with non-blocking assignments; the
   // pulse defaults at the top are overridden by later assignments in the same edge.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state        <= ST_ARM;
         cnt          <= '0;
         short_press  <= 1'b0;
         double_click <= 1'b0;
         long_press   <= 1'b0;
         repeat_tick  <= 1'b0;
      end else begin
         short_press  <= 1'b0;
         double_click <= 1'b0;
         long_press   <= 1'b0;
         repeat_tick  <= 1'b0;
         cnt          <= cnt + 1'b1;
         case (state)
            ST_ARM: begin
               cnt <= '0;
               if (!pressed) state <= ST_IDLE;
            end
            ST_IDLE: begin
               cnt <= '0;
               if (pressed) state <= ST_PRESS1;
            end
            ST_PRESS1: begin
               if (!pressed) begin
                  state <= ST_WAIT2;
                  cnt   <= '0;
               end else if (cnt == LONG_LAST) begin
                  long_press <= 1'b1;
                  state      <= ST_LONG_HOLD;
                  cnt        <= '0;
               end
            end
            ST_WAIT2: begin
               if (pressed) begin
                  state <= ST_PRESS2;
                  cnt   <= '0;
               end else if (cnt == DBL_LAST) begin
                  short_press <= 1'b1;
                  state       <= ST_IDLE;
                  cnt         <= '0;
               end
            end
            ST_PRESS2: begin
               if (!pressed) begin
                  double_click <= 1'b1;
                  state        <= ST_IDLE;
                  cnt          <= '0;
               end else if (cnt == LONG_LAST) begin
                  long_press <= 1'b1;
                  state      <= ST_LONG_HOLD;
                  cnt        <= '0;
               end
            end
            ST_LONG_HOLD: begin
               // A release wins over a repeat that would fire on the same edge.
               if (!pressed) begin
                  state <= ST_IDLE;
                  cnt   <= '0;
               end else if (cnt == REP_LAST) begin
                  repeat_tick <= 1'b1;
                  cnt         <= '0;
               end
            end
            default: begin
               state <= ST_ARM;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_key_event.sv
// Directed bench for key_event with scaled timing; expected pulses (event, edge number)
// are queued when stimulus is driven and popped when the DUT raises a pulse.
module tb_key_event;

   localparam int LONG   = 100;
   localparam int DBL    = 40;
   localparam int REP    = 20;

   localparam logic [3:0] EV_SHORT = 4'b0001;
   localparam logic [3:0] EV_DBL   = 4'b0010;
   localparam logic [3:0] EV_LONG  = 4'b0100;
   localparam logic [3:0] EV_REP   = 4'b1000;

   typedef struct packed {
      logic [3:0]  ev;
      logic [27:0] edge_no;
   } exp_t;

   logic sys_clk = 1'b0;
   logic sys_rst;
   logic key_status;
   logic short_press, double_click, long_press, repeat_tick, key_busy;

   exp_t exp_q[$];
   int   edge_n = 0;
   int   n_vec  = 0;
   int   n_err  = 0;

   always #5 sys_clk = ~sys_clk;

   key_event #(
      .PRESS_LEVEL(1'b0),
      .LONG_CYC   (LONG),
      .DBL_CYC    (DBL),
      .REPEAT_CYC (REP),
      .CNT_W      (26)
   ) dut (
      .sys_clk     (sys_clk),
      .sys_rst     (sys_rst),
      .key_status  (key_status),
      .short_press (short_press),
      .double_click(double_click),
      .long_press  (long_press),
      .repeat_tick (repeat_tick),
      .key_busy    (key_busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_ev(input logic [3:0] ev, input int at_edge);
      exp_q.push_back({ev, 28'(at_edge)});
   endtask

   // One clock: drive at the falling edge, let the rising edge sample, inspect at the next fall.
   task automatic tick(input logic key_lvl, input logic rst_lvl);
      logic [3:0] vec;
      exp_t       want;
      key_status = key_lvl;
      sys_rst    = rst_lvl;
      @(posedge sys_clk);
      edge_n++;
      @(negedge sys_clk);
      vec = {repeat_tick, long_press, double_click, short_press};
      if (vec !== 4'b0000) begin
         want = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
         check("pulse", {vec, 28'(edge_n)}, want);
      end
   endtask

   task automatic hold(input logic key_lvl, input int n);
      for (int i = 0; i < n; i++) tick(key_lvl, 1'b0);
   endtask

   task automatic drain(input string tag);
      hold(1'b1, 60);
      check(tag, exp_q.size(), 0);
   endtask

   int e;

   initial begin
      key_status = 1'b1;
      sys_rst    = 1'b1;

      // Reset state
      for (int i = 0; i < 3; i++) tick(1'b1, 1'b1);
      check("rst_outs", {short_press, double_click, long_press, repeat_tick}, 4'b0);
      check("rst_busy", key_busy, 1'b0);
      hold(1'b1, 3);
      check("idle_busy", key_busy, 1'b0);

      // Single short press: short after the 40th released sample
      e = edge_n;
      expect_ev(EV_SHORT, e + 10 + DBL);
      hold(1'b0, 5);
      check("press_busy", key_busy, 1'b1);
      hold(1'b0, 5);
      drain("short_done");
      check("short_busy_end", key_busy, 1'b0);

      // Double click with a 20-sample gap
      e = edge_n;
      expect_ev(EV_DBL, e + 41);
      hold(1'b0, 10);
      hold(1'b1, 20);
      hold(1'b0, 10);
      drain("dbl_done");

      // Double click with gap of DBL-1 released samples (boundary)
      e = edge_n;
      expect_ev(EV_DBL, e + 10 + (DBL - 1) + 6);
      hold(1'b0, 10);
      hold(1'b1, DBL - 1);
      hold(1'b0, 5);
      drain("dbl_edge_done");

      // Long press with auto-repeat, silent release
      e = edge_n;
      expect_ev(EV_LONG, e + LONG);
      expect_ev(EV_REP, e + LONG + REP);
      expect_ev(EV_REP, e + LONG + 2 * REP);
      expect_ev(EV_REP, e + LONG + 3 * REP);
      hold(1'b0, 165);
      drain("long_rep_done");

      // Press of LONG-1 samples is short-class
      e = edge_n;
      expect_ev(EV_SHORT, e + (LONG - 1) + DBL);
      hold(1'b0, LONG - 1);
      drain("long_m1_done");

      // Press of exactly LONG samples
      e = edge_n;
      expect_ev(EV_LONG, e + LONG);
      hold(1'b0, LONG);
      drain("long_exact_done");

      // Key held through reset: nothing while held, then a fresh short press works
      for (int i = 0; i < 5; i++) tick(1'b0, 1'b1);
      check("rst_held_outs", {short_press, double_click, long_press, repeat_tick}, 4'b0);
      check("rst_held_busy", key_busy, 1'b0);
      hold(1'b0, 10);
      check("arm_held_busy", key_busy, 1'b0);
      hold(1'b1, 5);
      e = edge_n;
      expect_ev(EV_SHORT, e + 10 + DBL);
      hold(1'b0, 10);
      drain("arm_short_done");

      // Reset in the middle of a WAIT2 gap discards the pending short press
      hold(1'b0, 10);
      hold(1'b1, 14);
      check("gap_busy", key_busy, 1'b1);
      tick(1'b1, 1'b1);
      check("gap_rst_outs", {short_press, double_click, long_press, repeat_tick}, 4'b0);
      check("gap_rst_busy", key_busy, 1'b0);
      drain("gap_rst_done");
      check("gap_rst_idle", key_busy, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
